// File: rtl/pipe_pkg.sv
// Shared types and helpers for the inter-stage pipeline latch.
`timescale 1ns/1ps
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // ISA nop; loaded into every lane on reset and flush.
  localparam logic [31:0] BUBBLE_DEFAULT = 32'b0;

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pipe_stage_latch_if.sv
// Upstream/downstream valid-ready bundle of one pipeline stage boundary.
`timescale 1ns/1ps
interface pipe_stage_latch_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_lane_reg.sv
// LANES x WIDTH enable register; async clear and sync load both write BUBBLE.
// Single-cycle load, no handshake of its own; load_bubble wins over en.
`timescale 1ns/1ps
module pipe_lane_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               LANES  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_DEFAULT)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_bubble,
  input  logic                   en,
  input  logic [LANES*WIDTH-1:0] d,
  output logic [LANES*WIDTH-1:0] q
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] lane_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        lane_q <= BUBBLE;
      end else if (load_bubble) begin
        lane_q <= BUBBLE;
      end else if (en) begin
        lane_q <= d[lane_lsb(k, WIDTH) +: WIDTH];
      end
    end

    assign q[lane_lsb(k, WIDTH) +: WIDTH] = lane_q;
  end

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with 2-entry skid: accept-to-out_valid 1 cycle, in_ready registered.
// Optional stall/flush counters under PIPE_STAGE_LATCH_PERF_EN; flush squashes everything.
`timescale 1ns/1ps
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               LANES  = 2,
  parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_DEFAULT)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  pipe_stage_latch_if.slave bus
`ifdef PIPE_STAGE_LATCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  state_t                 state_q, state_d;
  logic                   in_ready_q;
  logic                   main_v;
  logic                   accept, emit;
  logic                   main_en, main_from_skid, skid_en;
  logic [LANES*WIDTH-1:0] main_d, skid_d, main_nxt;

  assign main_v = (state_q != ST_EMPTY);
  assign accept = bus.in_valid & in_ready_q;
  assign emit   = main_v & bus.out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Precomputed from next state so in_ready never sees out_ready combinationally.
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_HALF;
            main_en = 1'b1;
          end
        end
        ST_HALF: begin
          if (accept && emit) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_d        = ST_HALF;
            main_en        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_nxt = main_from_skid ? skid_d : bus.in_data;

  pipe_lane_reg #(.WIDTH(WIDTH), .LANES(LANES), .BUBBLE(BUBBLE)) u_main (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_bubble (flush),
    .en          (main_en),
    .d           (main_nxt),
    .q           (main_d)
  );

  pipe_lane_reg #(.WIDTH(WIDTH), .LANES(LANES), .BUBBLE(BUBBLE)) u_skid (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_bubble (flush),
    .en          (skid_en),
    .d           (bus.in_data),
    .q           (skid_d)
  );

  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;
  assign bus.in_ready  = in_ready_q;

`ifdef PIPE_STAGE_LATCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (main_v && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                    flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed vector table plus reference-queue random run for pipe_stage_latch.
`timescale 1ns/1ps
module tb_pipe_stage_latch;
  import pipe_pkg::*;

  localparam int W  = 32;
  localparam int L  = 2;
  localparam int NV = 18;

  logic clock;
  logic reset_n;
  logic flush;
  int   checks;
  int   errors;

  pipe_stage_latch_if #(.WIDTH(W), .LANES(L)) bus ();

`ifdef PIPE_STAGE_LATCH_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_stage_latch #(.WIDTH(W), .LANES(L)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef PIPE_STAGE_LATCH_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [L*W-1:0] d;
    logic          ordy;
    logic          ov;
    logic          ir;
    logic [L*W-1:0] od;
  } vec_t;

  vec_t vecs[NV];

  function automatic logic [L*W-1:0] dw(input logic [31:0] pc, input logic [31:0] ir);
    logic [L*W-1:0] r;
    r = '0;
    r[lane_lsb(0, W) +: W] = pc;
    r[lane_lsb(1, W) +: W] = ir;
    return r;
  endfunction

  function automatic vec_t mkv(input logic fl, input logic iv, input logic [L*W-1:0] d,
                               input logic ordy, input logic ov, input logic ir,
                               input logic [L*W-1:0] od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.od = od;
    return v;
  endfunction

  task automatic check(input string name, input logic [L*W-1:0] act, input logic [L*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [L*W-1:0] d, input logic ordy);
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  logic [L*W-1:0] q[$];
  logic [L*W-1:0] rd;
  logic           rdy_before;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Streaming, stall fill, flush in FULL, flush in HALF with same-cycle accept/emit.
    vecs[0]  = mkv(0, 1, dw(32'h100, 32'hA0), 1, 1, 1, dw(32'h100, 32'hA0));
    vecs[1]  = mkv(0, 1, dw(32'h104, 32'hA1), 1, 1, 1, dw(32'h104, 32'hA1));
    vecs[2]  = mkv(0, 1, dw(32'h108, 32'hA2), 1, 1, 1, dw(32'h108, 32'hA2));
    vecs[3]  = mkv(0, 1, dw(32'h10C, 32'hA3), 1, 1, 1, dw(32'h10C, 32'hA3));
    vecs[4]  = mkv(0, 0, '0,                  1, 0, 1, dw(32'h10C, 32'hA3));
    vecs[5]  = mkv(0, 1, dw(32'h200, 32'hB0), 0, 1, 1, dw(32'h200, 32'hB0));
    vecs[6]  = mkv(0, 1, dw(32'h204, 32'hB1), 0, 1, 0, dw(32'h200, 32'hB0));
    vecs[7]  = mkv(0, 1, dw(32'h208, 32'hB2), 0, 1, 0, dw(32'h200, 32'hB0));
    vecs[8]  = mkv(0, 0, '0,                  1, 1, 1, dw(32'h204, 32'hB1));
    vecs[9]  = mkv(0, 0, '0,                  1, 0, 1, dw(32'h204, 32'hB1));
    vecs[10] = mkv(0, 1, dw(32'h210, 32'hC0), 0, 1, 1, dw(32'h210, 32'hC0));
    vecs[11] = mkv(0, 1, dw(32'h214, 32'hC1), 0, 1, 0, dw(32'h210, 32'hC0));
    vecs[12] = mkv(1, 1, dw(32'h300, 32'hC2), 0, 0, 1, '0);
    vecs[13] = mkv(0, 0, '0,                  1, 0, 1, '0);
    vecs[14] = mkv(0, 1, dw(32'h400, 32'hD0), 0, 1, 1, dw(32'h400, 32'hD0));
    vecs[15] = mkv(1, 1, dw(32'h404, 32'hD1), 1, 0, 1, '0);
    vecs[16] = mkv(0, 1, dw(32'h408, 32'hD2), 1, 1, 1, dw(32'h408, 32'hD2));
    vecs[17] = mkv(0, 0, '0,                  1, 0, 1, dw(32'h408, 32'hD2));

    repeat (3) @(negedge clock);
    check("rst_ov", {63'b0, bus.out_valid}, 64'd0);
    check("rst_ir", {63'b0, bus.in_ready}, 64'd1);
    check("rst_od", bus.out_data, '0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_ov", i), {63'b0, bus.out_valid}, {63'b0, vecs[i].ov});
      check($sformatf("v%0d_ir", i), {63'b0, bus.in_ready}, {63'b0, vecs[i].ir});
      check($sformatf("v%0d_od", i), bus.out_data, vecs[i].od);
    end

    // Fill to FULL, then assert reset away from any clock edge.
    @(negedge clock); drive(0, 1, dw(32'h500, 32'hE0), 0);
    @(negedge clock); drive(0, 1, dw(32'h504, 32'hE1), 0);
    @(negedge clock); drive(0, 0, '0, 0);
    check("full_ir", {63'b0, bus.in_ready}, 64'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ov", {63'b0, bus.out_valid}, 64'd0);
    check("arst_ir", {63'b0, bus.in_ready}, 64'd1);
    check("arst_od", bus.out_data, '0);
    @(negedge clock);
    reset_n = 1'b1;

    // Random traffic against an in-order reference queue.
    for (int c = 0; c < 1005; c++) begin
      @(negedge clock);
      rdy_before = bus.in_ready;
      if (c < 1000) drive(0, 1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom_range(1)));
      else          drive(0, 0, '0, 1);
      #1;
      check("rdy_indep", {63'b0, bus.in_ready}, {63'b0, rdy_before});
      check("occ_ov", {63'b0, bus.out_valid}, {63'b0, q.size() != 0});
      check("occ_ir", {63'b0, bus.in_ready}, {63'b0, q.size() < 2});
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        rd = q.pop_front();
        check("rand_od", bus.out_data, rd);
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
    end
    check("drain_empty", 64'(q.size()), 64'd0);

`ifdef PIPE_STAGE_LATCH_PERF_EN
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    check("perf_rst_stall", 64'(stall_cnt), 64'd0);
    check("perf_rst_flush", 64'(flush_cnt), 64'd0);
    @(negedge clock); drive(0, 1, dw(32'h600, 32'hF0), 0);
    repeat (5) begin
      @(negedge clock); drive(0, 0, '0, 0);
    end
    @(negedge clock); drive(1, 0, '0, 1);
    @(negedge clock); drive(1, 0, '0, 1);
    @(negedge clock); drive(0, 0, '0, 1);
    check("perf_stall", 64'(stall_cnt), 64'd5);
    check("perf_flush", 64'(flush_cnt), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
